// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: state encoding,
// register map and priority helpers.
// Imported by irq_ctrl and irq_sync_edge.
package irq_pkg;

    localparam int IRQ_LINES = 8;

    // Register map (2-bit address)
    localparam logic [1:0] IRQ_A_IRR  = 2'd0;
    localparam logic [1:0] IRQ_A_IMR  = 2'd1;
    localparam logic [1:0] IRQ_A_ISR  = 2'd2;
    localparam logic [1:0] IRQ_A_BASE = 2'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_REQ   = 2'd1,
        IRQ_SERVE = 2'd2
    } irq_state_t;

    // Index of the lowest set bit (line 0 is highest priority).
    // Returns 0 when no bit is set; callers qualify with a separate |v.
    function automatic logic [2:0] lowest_index(input logic [IRQ_LINES-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = IRQ_LINES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // True when an in-service line of equal or higher priority than p
    // exists; such a line blocks p from nesting on top of it.
    function automatic logic isr_blocks(input logic [IRQ_LINES-1:0] isr,
                                        input logic [2:0]           p);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < IRQ_LINES; i++) begin
            if ((i <= int'(p)) && isr[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchronizer followed by a rising-edge detector.
// Latency: rise pulses in the cycle after SYNC_STAGES edges have sampled the line high.
// No backpressure: rise is a single-cycle pulse with no handshake.
//
// Ports:
//   clock, reset : core clock, asynchronous active-high reset
//   line         : raw asynchronous request input
//   rise         : one-cycle pulse on a synchronized 0->1 transition
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic line,
    output logic rise
);

    // Fewer than two flops is not a safe synchronizer; clamp silently.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], line};
            prev <= sync[STAGES-1];
        end
    end

    // Combinational from flops so the IRR set lands on the edge after the
    // last synchronizer stage goes high.
    assign rise = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: edge-latched requests, mask, nesting
// via in-service tracking, intr/irq handshake with the core.
// Latency: request sampled at edge k -> IRR at k+SYNC_STAGES -> intr after k+SYNC_STAGES+1.
// Backpressure: the vector is held in REQ until intr_ack; register reads are 1-cycle registered.
//
// Ports:
//   clock, reset     : core clock, asynchronous active-high reset
//   irq_line[7:0]    : asynchronous request lines, line 0 highest priority
//   intr, irq[7:0]   : request and vector to the core (irq valid while intr=1)
//   intr_ack         : single-cycle pulse, vector taken
//   port_a/i/w/o     : byte register port (IRR/EOI, IMR, ISR, BASE)
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE = 8'h08,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] irq_line,
    output logic       intr,
    output logic [7:0] irq,
    input  logic       intr_ack,
    input  logic [1:0] port_a,
    input  logic [7:0] port_i,
    input  logic       port_w,
    output logic [7:0] port_o
);

    logic [IRQ_LINES-1:0] rise;
    logic [IRQ_LINES-1:0] irr;
    logic [IRQ_LINES-1:0] imr;
    logic [IRQ_LINES-1:0] isr;
    logic [7:0]           base;
    irq_state_t           state;
    logic [2:0]           cur_p;
    logic [7:0]           vec;

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    for (genvar g = 0; g < IRQ_LINES; g++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clock (clock),
            .reset (reset),
            .line  (irq_line[g]),
            .rise  (rise[g])
        );
    end

    // ------------------------------------------------------------------
    // Candidate selection
    // ------------------------------------------------------------------
    logic [IRQ_LINES-1:0] cand;
    logic [2:0]           cand_p;
    logic                 eligible;

    always_comb begin
        cand     = irr & ~imr;
        cand_p   = lowest_index(cand);
        eligible = (|cand) && !isr_blocks(isr, cand_p);
    end

    // ------------------------------------------------------------------
    // Next-state for IRR / ISR
    // ------------------------------------------------------------------
    logic                 reg_wr_irr;
    logic [IRQ_LINES-1:0] eoi_mask;
    logic [IRQ_LINES-1:0] serve_mask;
    logic [IRQ_LINES-1:0] irr_next;
    logic [IRQ_LINES-1:0] isr_next;

    always_comb begin
        reg_wr_irr = port_w && (port_a == IRQ_A_IRR);
        // Lowest set bit of the current ISR as a one-hot; zero when ISR is empty.
        eoi_mask   = reg_wr_irr ? (isr & (~isr + 8'd1)) : '0;
        serve_mask = (state == IRQ_SERVE) ? (8'b1 << cur_p) : '0;
        // A fresh edge on the line being served keeps the request pending.
        irr_next   = (irr & ~serve_mask) | rise;
        // EOI acts on the pre-serve ISR; SERVE's set is applied afterwards.
        isr_next   = (isr & ~eoi_mask) | serve_mask;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irr <= '0;
            isr <= '0;
        end else begin
            irr <= irr_next;
            isr <= isr_next;
        end
    end

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imr  <= 8'hFF;
            base <= VECTOR_BASE;
        end else if (port_w) begin
            if (port_a == IRQ_A_IMR) begin
                imr <= port_i;
            end
            if (port_a == IRQ_A_BASE) begin
                base <= port_i;
            end
        end
    end

    // Read data follows the address one cycle later, like a block RAM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            port_o <= '0;
        end else begin
            case (port_a)
                IRQ_A_IRR:  port_o <= irr;
                IRQ_A_IMR:  port_o <= imr;
                IRQ_A_ISR:  port_o <= isr;
                IRQ_A_BASE: port_o <= base;
                default:    port_o <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IRQ_IDLE;
            cur_p <= 3'd0;
            vec   <= VECTOR_BASE;
        end else begin
            case (state)
                IRQ_IDLE: begin
                    if (eligible) begin
                        state <= IRQ_REQ;
                        cur_p <= cand_p;
                        // 8-bit wraparound is intended.
                        vec   <= base + {5'd0, cand_p};
                    end
                end
                IRQ_REQ: begin
                    // The ack takes priority over a same-cycle mask change.
                    if (intr_ack) begin
                        state <= IRQ_SERVE;
                    end else if (!cand[cur_p]) begin
                        state <= IRQ_IDLE;
                    end
                end
                IRQ_SERVE: begin
                    state <= IRQ_IDLE;
                end
                default: begin
                    state <= IRQ_IDLE;
                end
            endcase
        end
    end

    assign intr = (state == IRQ_REQ);
    assign irq  = vec;

endmodule
